// File: rtl/conv_pkg.sv
// Shared sizing for the 3D-convolution datapath: defaults, derived dimensions and address widths.
// Latency: none (compile-time constants and constant functions only).
// Backpressure: not applicable.
// Optional feature macro: CONV_ZERO_PAD_EN (adds the zero-padding border to the output dimensions).
package conv_pkg;

   // 1 when the zero-padding border is compiled in. Without it PAD is multiplied away.
`ifdef CONV_ZERO_PAD_EN
   localparam int PAD_ON = 1;
`else
   localparam int PAD_ON = 0;
`endif

   // Bits needed to address 'depth' entries. Never returns 0, so a depth-1 RAM still gets a 1-bit port.
   function automatic int clog2w(input int depth);
      int w;
      w = 0;
      while ((1 << w) < depth) w = w + 1;
      return (w < 1) ? 1 : w;
   endfunction

   // Elements in one kernel window.
   function automatic int win_len(input int k, input int ch);
      return k * k * ch;
   endfunction

   // Window positions along one axis of the (optionally padded) input map.
   function automatic int out_dim(input int img, input int k, input int stride, input int pad);
      return (img + 2 * pad - k) / stride + 1;
   endfunction

   function automatic int in_aw(input int h, input int w, input int ch);
      return clog2w(h * w * ch);
   endfunction

   function automatic int w_aw(input int nf, input int k, input int ch);
      return clog2w(nf * win_len(k, ch));
   endfunction

   function automatic int o_aw(input int nf, input int oh, input int ow);
      return clog2w(nf * oh * ow);
   endfunction

   // Default geometry, shared with the controller and MAC.
   localparam int DEF_IMG_H     = 4;
   localparam int DEF_IMG_W     = 4;
   localparam int DEF_IN_CH     = 2;
   localparam int DEF_K         = 2;
   localparam int DEF_STRIDE    = 1;
   localparam int DEF_N_FILTERS = 2;
   localparam int DEF_PAD       = 1;

   localparam int DEF_OUT_W = out_dim(DEF_IMG_W, DEF_K, DEF_STRIDE, DEF_PAD * PAD_ON);
   localparam int DEF_OUT_H = out_dim(DEF_IMG_H, DEF_K, DEF_STRIDE, DEF_PAD * PAD_ON);
   localparam int DEF_IAW   = in_aw(DEF_IMG_H, DEF_IMG_W, DEF_IN_CH);
   localparam int DEF_WAW   = w_aw(DEF_N_FILTERS, DEF_K, DEF_IN_CH);
   localparam int DEF_OAW   = o_aw(DEF_N_FILTERS, DEF_OUT_H, DEF_OUT_W);

endpackage

// File: rtl/conv_window_addr_gen_if.sv
// Controller/RAM-side bundle of the convolution address generator.
// Latency: none (wires only).
// Backpressure: none; the controller paces everything through the counter controls.
// Ports: master = controller (drives counter controls, reads flags/addresses);
//        slave  = conv_window_addr_gen. pad_zero exists only with CONV_ZERO_PAD_EN.
interface conv_window_addr_gen_if #(
   parameter int IAW = conv_pkg::DEF_IAW,
   parameter int WAW = conv_pkg::DEF_WAW,
   parameter int OAW = conv_pkg::DEF_OAW
);
   // Counter controls from the controller
   logic           rst_cnt_window;
   logic           rst_cnt_col;
   logic           rst_cnt_row;
   logic           cen_cnt_window;
   logic           mac_en;
   logic           sel;
   // Status flags back to the controller
   logic           one_window_done;
   logic           one_row_done;
   logic           done_row;
   // RAM addressing
   logic [IAW-1:0] in_addr;
   logic [WAW-1:0] w_addr;
   logic [OAW-1:0] out_addr;
   logic           addr_valid;
   logic           out_wr_en;
`ifdef CONV_ZERO_PAD_EN
   logic           pad_zero;
`endif

   modport master (
      output rst_cnt_window, rst_cnt_col, rst_cnt_row, cen_cnt_window, mac_en, sel,
      input  one_window_done, one_row_done, done_row,
      input  in_addr, w_addr, out_addr, addr_valid, out_wr_en
`ifdef CONV_ZERO_PAD_EN
      , input pad_zero
`endif
   );

   modport slave (
      input  rst_cnt_window, rst_cnt_col, rst_cnt_row, cen_cnt_window, mac_en, sel,
      output one_window_done, one_row_done, done_row,
      output in_addr, w_addr, out_addr, addr_valid, out_wr_en
`ifdef CONV_ZERO_PAD_EN
      , output pad_zero
`endif
   );

endinterface

// File: rtl/conv_kernel_cnt.sv
// Nested kx (fastest) / ky / c counter walking one kernel window, with a last-element flag.
// Latency: counters update at the clock edge after i_clr/i_en; o_last is combinational from them.
// Backpressure: none; at the last element the counters hold until i_clr, they never wrap.
// Ports: clk, reset (sync, active-high); i_clr zeroes all three (wins over i_en);
//        i_en advances by one element; o_kx/o_ky/o_c current element; o_last = last element.
module conv_kernel_cnt
   import conv_pkg::*;
#(
   parameter int K     = DEF_K,
   parameter int IN_CH = DEF_IN_CH,
   parameter int KW    = clog2w(K),
   parameter int CW    = clog2w(IN_CH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [KW-1:0] o_kx,
   output logic [KW-1:0] o_ky,
   output logic [CW-1:0] o_c,
   output logic          o_last
);

   localparam logic [KW-1:0] K_LAST = KW'(K - 1);
   localparam logic [CW-1:0] C_LAST = CW'(IN_CH - 1);

   logic [KW-1:0] r_kx;
   logic [KW-1:0] r_ky;
   logic [CW-1:0] r_c;
   logic          w_last;

   assign w_last = (r_kx == K_LAST) && (r_ky == K_LAST) && (r_c == C_LAST);

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_kx <= '0;
         r_ky <= '0;
         r_c  <= '0;
      end else if (i_en && !w_last) begin
         // Ripple carry kx -> ky -> c. Excluding w_last guarantees c never overflows.
         if (r_kx != K_LAST) begin
            r_kx <= r_kx + 1'b1;
         end else begin
            r_kx <= '0;
            if (r_ky != K_LAST) begin
               r_ky <= r_ky + 1'b1;
            end else begin
               r_ky <= '0;
               r_c  <= r_c + 1'b1;
            end
         end
      end
   end

   assign o_kx   = r_kx;
   assign o_ky   = r_ky;
   assign o_c    = r_c;
   assign o_last = w_last;

endmodule

// File: rtl/conv_window_addr_gen.sv
// Window/column/row counters and feature, weight and result RAM address generation for 3D conv.
// Latency: in_addr/w_addr/addr_valid(/pad_zero) registered, 1 cycle; flags, out_wr_en, out_addr combinational.
// Backpressure: none; the controller steps the counters explicitly and the MAC consumes every valid address.
// Ports: clk, reset (sync, active-high); io_bus (slave side of conv_window_addr_gen_if) carries the
//        counter controls in and the status flags / RAM addresses out.
// Optional feature macro: CONV_ZERO_PAD_EN (virtual PAD border, pad_zero output).
module conv_window_addr_gen
   import conv_pkg::*;
#(
   parameter int IMG_H     = DEF_IMG_H,
   parameter int IMG_W     = DEF_IMG_W,
   parameter int IN_CH     = DEF_IN_CH,
   parameter int K         = DEF_K,
   parameter int STRIDE    = DEF_STRIDE,
   parameter int N_FILTERS = DEF_N_FILTERS,
   parameter int PAD       = DEF_PAD
) (
   input  logic                   clk,
   input  logic                   reset,
   conv_window_addr_gen_if.slave  io_bus
);

   // PAD contributes to the geometry only when the padding border is compiled in.
   localparam int PAD_EFF = PAD * PAD_ON;
   localparam int WIN_LEN = win_len(K, IN_CH);
   localparam int OUT_W   = out_dim(IMG_W, K, STRIDE, PAD_EFF);
   localparam int OUT_H   = out_dim(IMG_H, K, STRIDE, PAD_EFF);
   localparam int IAW     = in_aw(IMG_H, IMG_W, IN_CH);
   localparam int WAW     = w_aw(N_FILTERS, K, IN_CH);
   localparam int OAW     = o_aw(N_FILTERS, OUT_H, OUT_W);
   localparam int KW      = clog2w(K);
   localparam int CW      = clog2w(IN_CH);
   localparam int COLW    = clog2w(OUT_W);
   localparam int ROWW    = clog2w(OUT_H);

   localparam logic [COLW-1:0] COL_LAST = COLW'(OUT_W - 1);
   localparam logic [ROWW-1:0] ROW_LAST = ROWW'(OUT_H - 1);

   // Kernel element position
   logic [KW-1:0]   w_kx;
   logic [KW-1:0]   w_ky;
   logic [CW-1:0]   w_c;
   logic            w_last;

   // Output-map position
   logic [COLW-1:0] r_col_cnt;
   logic [ROWW-1:0] r_row_cnt;
   logic            w_col_last;
   logic            w_row_last;

   // Address datapath
   int              w_vrow;
   int              w_vcol;
   logic            w_pad;
   logic [IAW-1:0]  w_in_addr_nxt;
   logic [WAW-1:0]  w_w_addr_nxt;
   logic [IAW-1:0]  r_in_addr;
   logic [WAW-1:0]  r_w_addr;
   logic            r_addr_valid;
   logic            r_pad_zero;

   conv_kernel_cnt #(
      .K     (K),
      .IN_CH (IN_CH)
   ) u_kernel_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (io_bus.rst_cnt_window),
      .i_en   (io_bus.cen_cnt_window),
      .o_kx   (w_kx),
      .o_ky   (w_ky),
      .o_c    (w_c),
      .o_last (w_last)
   );

   assign w_col_last = (r_col_cnt == COL_LAST);
   assign w_row_last = (r_row_cnt == ROW_LAST);

   // Column steps when a finished window is cleared; the row steps when the column is cleared
   // from its last position. A row clear overrides a row step in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_col_cnt <= '0;
         r_row_cnt <= '0;
      end else begin
         if (io_bus.rst_cnt_col) begin
            r_col_cnt <= '0;
            if (!io_bus.rst_cnt_row && w_col_last && !w_row_last) begin
               r_row_cnt <= r_row_cnt + 1'b1;
            end
         end else if (io_bus.rst_cnt_window && w_last && !w_col_last) begin
            r_col_cnt <= r_col_cnt + 1'b1;
         end
         if (io_bus.rst_cnt_row) begin
            r_row_cnt <= '0;
         end
      end
   end

   // Address of the element the counters point at now; it is registered so the RAM sees it
   // together with addr_valid on the following cycle.
   always_comb begin
      w_vrow = '0;
      w_vcol = '0;
      w_pad  = 1'b0;
`ifdef CONV_ZERO_PAD_EN
      // Coordinates in the unpadded map; anything outside it reads as a zero operand.
      w_vrow = int'(r_row_cnt) * STRIDE + int'(w_ky) - PAD_EFF;
      w_vcol = int'(r_col_cnt) * STRIDE + int'(w_kx) - PAD_EFF;
      w_pad  = (w_vrow < 0) || (w_vrow >= IMG_H) || (w_vcol < 0) || (w_vcol >= IMG_W);
`else
      w_vrow = int'(r_row_cnt) * STRIDE + int'(w_ky);
      w_vcol = int'(r_col_cnt) * STRIDE + int'(w_kx);
`endif
      if (w_pad) begin
         w_in_addr_nxt = '0;
      end else begin
         w_in_addr_nxt = IAW'(int'(w_c) * IMG_H * IMG_W + w_vrow * IMG_W + w_vcol);
      end
      // Filters sit back-to-back in weight RAM, each laid out c-major, then ky, then kx.
      w_w_addr_nxt = WAW'(int'(io_bus.sel) * WIN_LEN + int'(w_c) * K * K
                          + int'(w_ky) * K + int'(w_kx));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_addr    <= '0;
         r_w_addr     <= '0;
         r_addr_valid <= 1'b0;
         r_pad_zero   <= 1'b0;
      end else begin
         r_in_addr    <= w_in_addr_nxt;
         r_w_addr     <= w_w_addr_nxt;
         r_addr_valid <= io_bus.mac_en;
         r_pad_zero   <= w_pad;
      end
   end

   assign io_bus.one_window_done = w_last;
   assign io_bus.one_row_done    = w_col_last;
   assign io_bus.done_row        = w_row_last;
   assign io_bus.in_addr         = r_in_addr;
   assign io_bus.w_addr          = r_w_addr;
   assign io_bus.addr_valid      = r_addr_valid;

   // The window clear is also the accumulator clear, which only lands at the next edge, so the
   // finished sum is still on the MAC output while this strobe is high. Suppressed during reset.
   assign io_bus.out_wr_en = io_bus.rst_cnt_window & w_last & ~reset;
   assign io_bus.out_addr  = OAW'(int'(io_bus.sel) * OUT_H * OUT_W
                                  + int'(r_row_cnt) * OUT_W + int'(r_col_cnt));

`ifdef CONV_ZERO_PAD_EN
   assign io_bus.pad_zero = r_pad_zero;
`else
   // Tracked but not exported: without padding it is constant 0.
   logic w_pad_unused;
   assign w_pad_unused = r_pad_zero;
`endif

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Self-checking bench for conv_window_addr_gen: directed steps plus a randomized phase against
// a reference model that tracks the window as a flat element index and derives kx/ky/c by division.
module tb_conv_window_addr_gen;

   localparam int IMG_H = 4, IMG_W = 4, IN_CH = 2, K = 2, STRIDE = 1, N_FILTERS = 2;
`ifdef CONV_ZERO_PAD_EN
   localparam int PADM = 1;
`else
   localparam int PADM = 0;
`endif
   localparam int WIN_LEN = K * K * IN_CH;
   localparam int OUT_W   = (IMG_W + 2 * PADM - K) / STRIDE + 1;
   localparam int OUT_H   = (IMG_H + 2 * PADM - K) / STRIDE + 1;

   logic clk;
   logic reset;

   conv_window_addr_gen_if bus ();

   conv_window_addr_gen dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Reference state: flat kernel element index and output-map position.
   int m_e, m_col, m_row;
   int wr_q[$];
   int wmin, wmax;
   logic        last_wr;
   logic [31:0] last_oaddr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_pad(input int e, input int col, input int row);
      int vr, vc;
      vr = row * STRIDE + (e / K) % K - PADM;
      vc = col * STRIDE + e % K - PADM;
      return (vr < 0) || (vr >= IMG_H) || (vc < 0) || (vc >= IMG_W);
   endfunction

   function automatic int model_in_addr(input int e, input int col, input int row);
      int vr, vc, c;
      c  = e / (K * K);
      vr = row * STRIDE + (e / K) % K - PADM;
      vc = col * STRIDE + e % K - PADM;
      if (model_pad(e, col, row)) return 0;
      return c * IMG_H * IMG_W + vr * IMG_W + vc;
   endfunction

   task automatic drive(input bit rw, input bit rc, input bit rr, input bit cen, input bit mac, input bit sl);
      bus.rst_cnt_window = rw;
      bus.rst_cnt_col    = rc;
      bus.rst_cnt_row    = rr;
      bus.cen_cnt_window = cen;
      bus.mac_en         = mac;
      bus.sel            = sl;
   endtask

   // One clock: checks combinational outputs before the edge, registered outputs after it.
   task automatic cycle(input bit rw, input bit rc, input bit rr, input bit cen, input bit mac, input bit sl);
      bit done;
      int x_in, x_w;
      bit x_pz, x_v;
      drive(rw, rc, rr, cen, mac, sl);
      #1;
      done = (m_e == WIN_LEN - 1);
      check("one_window_done", 32'(bus.one_window_done), 32'(done));
      check("one_row_done", 32'(bus.one_row_done), 32'(m_col == OUT_W - 1));
      check("done_row", 32'(bus.done_row), 32'(m_row == OUT_H - 1));
      check("out_wr_en", 32'(bus.out_wr_en), 32'(rw && done));
      if (rw && done)
         check("out_addr", 32'(bus.out_addr), 32'(sl * OUT_H * OUT_W + m_row * OUT_W + m_col));
      last_wr    = bus.out_wr_en;
      last_oaddr = 32'(bus.out_addr);
      if (bus.out_wr_en === 1'b1) wr_q.push_back(int'(bus.out_addr));
      x_in = model_in_addr(m_e, m_col, m_row);
      x_pz = model_pad(m_e, m_col, m_row);
      x_w  = sl * WIN_LEN + m_e;
      x_v  = mac;
      // Position update from the counter rules
      if (rc) begin
         if (!rr && m_col == OUT_W - 1 && m_row < OUT_H - 1) m_row++;
         m_col = 0;
      end else if (rw && done && m_col < OUT_W - 1) begin
         m_col++;
      end
      if (rr) m_row = 0;
      if (rw) m_e = 0;
      else if (cen && !done) m_e++;
      @(posedge clk);
      @(negedge clk);
      check("in_addr", 32'(bus.in_addr), 32'(x_in));
      check("w_addr", 32'(bus.w_addr), 32'(x_w));
      check("addr_valid", 32'(bus.addr_valid), 32'(x_v));
`ifdef CONV_ZERO_PAD_EN
      check("pad_zero", 32'(bus.pad_zero), 32'(x_pz));
`endif
      if (bus.addr_valid === 1'b1) begin
         if (int'(bus.w_addr) < wmin) wmin = int'(bus.w_addr);
         if (int'(bus.w_addr) > wmax) wmax = int'(bus.w_addr);
      end
   endtask

   // Reset for one edge; with busy=1 the controls are active while reset is applied.
   task automatic do_reset(input bit busy);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, busy, busy, busy);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      m_e = 0; m_col = 0; m_row = 0;
   endtask

   task automatic check_idle(input string tag);
      #1;
      check({tag, "_in_addr"}, 32'(bus.in_addr), 32'd0);
      check({tag, "_w_addr"}, 32'(bus.w_addr), 32'd0);
      check({tag, "_addr_valid"}, 32'(bus.addr_valid), 32'd0);
      check({tag, "_one_window_done"}, 32'(bus.one_window_done), 32'(WIN_LEN == 1));
      check({tag, "_one_row_done"}, 32'(bus.one_row_done), 32'(OUT_W == 1));
      check({tag, "_done_row"}, 32'(bus.done_row), 32'(OUT_H == 1));
      check({tag, "_out_wr_en"}, 32'(bus.out_wr_en), 32'd0);
   endtask

   int exp_in[8] = '{0, 1, 4, 5, 16, 17, 20, 21};

   initial begin
      n_checks = 0;
      n_fail   = 0;
      wmin     = 1 << 30;
      wmax     = -1;
      reset    = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // Reset state
      do_reset(1'b0);
      check_idle("reset");

`ifndef CONV_ZERO_PAD_EN
      // Window walk, filter 0
      cycle(1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         cycle(0, 0, 0, 1, 1, 0);
         check("walk_in_addr", 32'(bus.in_addr), 32'(exp_in[k-1]));
         check("walk_w_addr", 32'(bus.w_addr), 32'(k - 1));
         check("walk_window_done", 32'(bus.one_window_done), 32'(k >= 7));
      end
      // Column advance on the window clear of a finished window
      cycle(1, 0, 0, 0, 0, 0);
      check("col_adv_wr", 32'(last_wr), 32'd1);
      check("col_adv_oaddr", last_oaddr, 32'd0);
      cycle(0, 0, 0, 1, 1, 0);
      check("col1_start", 32'(bus.in_addr), 32'd1);
      for (int k = 0; k < 7; k++) cycle(0, 0, 0, 1, 1, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 0);
      check("col2_start", 32'(bus.in_addr), 32'd2);
      for (int k = 0; k < 7; k++) cycle(0, 0, 0, 1, 1, 0);
      // Row wrap from the last column
      check("row_wrap_pre_row_done", 32'(bus.one_row_done), 32'd1);
      cycle(1, 1, 0, 0, 0, 0);
      check("row_wrap_post_row_done", 32'(bus.one_row_done), 32'd0);
      cycle(0, 0, 0, 1, 1, 0);
      check("row1_start", 32'(bus.in_addr), 32'd4);
`else
      // Padded border: window (0,0) starts outside the map
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 0);
      check("pad_first_pz", 32'(bus.pad_zero), 32'd1);
      check("pad_first_in", 32'(bus.in_addr), 32'd0);
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 1, 0);
      check("pad_k11_pz", 32'(bus.pad_zero), 32'd0);
      check("pad_k11_in", 32'(bus.in_addr), 32'd0);
`endif

      // Randomized controls against the model
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      // Full map with filter 1
      do_reset(1'b0);
      wr_q.delete();
      wmin = 1 << 30;
      wmax = -1;
      cycle(1, 0, 0, 0, 0, 1);
      for (int w = 0; w < OUT_W * OUT_H; w++) begin
         for (int i = 0; i < WIN_LEN; i++) cycle(0, 0, 0, 1, 1, 1);
         check("map_done_row", 32'(bus.done_row), 32'(w / OUT_W == OUT_H - 1));
         cycle(1, (w % OUT_W) == OUT_W - 1, 0, 0, 0, 1);
      end
      check("map_wr_count", 32'(wr_q.size()), 32'(OUT_W * OUT_H));
      for (int i = 0; i < wr_q.size(); i++)
         check("map_out_addr", 32'(wr_q[i]), 32'(OUT_H * OUT_W + i));
      check("map_w_min", 32'(wmin), 32'(WIN_LEN));
      check("map_w_max", 32'(wmax), 32'(2 * WIN_LEN - 1));

      // Reset in the middle of a walk
      do_reset(1'b0);
      cycle(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) cycle(0, 0, 0, 1, 1, 0);
      do_reset(1'b1);
      check_idle("midreset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
